// File: rtl/bcd_display_scheduler_if.sv
// Handshake and display bus for bcd_display_scheduler: source drives value/valid,
// the scheduler returns ready, digit codes, busy and overflow.
interface bcd_display_scheduler_if #(
  parameter int WIDTH  = 16,
  parameter int DIGITS = 5
);
  logic [WIDTH-1:0]    value;
  logic                valid;
  logic                ready;
  logic [4*DIGITS-1:0] bcd;
  logic                busy;
  logic                overflow;

  modport master (output value, valid, input ready, bcd, busy, overflow);
  modport slave  (input value, valid, output ready, bcd, busy, overflow);
endinterface

// File: rtl/bcd_display_scheduler.sv
// Rate-limited serial binary-to-BCD converter for the seven-segment digits.
// Optional macro LEADING_ZERO_BLANK_EN blanks zero digits above the leading nonzero one.
//
// state      | meaning
// S_IDLE     | ready for a new reading (once out of reset)
// S_CONVERT  | double-dabble, one bit per clk, WIDTH clks
// S_COMMIT   | load display digits and overflow flag
// S_HOLD     | wait until UPDATE_PERIOD clks since capture
module bcd_display_scheduler #(
  parameter int WIDTH         = 16,
  parameter int DIGITS        = 5,
  parameter int UPDATE_PERIOD = 5_000_000
) (
  input  logic                    clk,
  input  logic                    reset,
  bcd_display_scheduler_if.slave  bus
);
  localparam int BW = 4 * DIGITS;
  localparam int CW = $clog2(WIDTH + 1);
  localparam int HW = (UPDATE_PERIOD < 2) ? 1 : $clog2(UPDATE_PERIOD + 1);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_CONVERT = 2'd1;
  localparam logic [1:0] S_COMMIT  = 2'd2;
  localparam logic [1:0] S_HOLD    = 2'd3;

  localparam logic [HW-1:0] HOLD_MAX = '1;
  localparam logic [HW-1:0] HOLD_TC  = HW'(UPDATE_PERIOD);

  logic [1:0]       state;
  logic             armed;
  logic [WIDTH-1:0] shreg;
  logic [BW-1:0]    work;
  logic [BW-1:0]    adj;
  logic [BW-1:0]    disp;
  logic             ovf;
  logic [CW-1:0]    bit_cnt;
  logic [HW-1:0]    hold_cnt;
  logic [BW-1:0]    bcd_q;
  logic             ovf_q;

  always_comb begin
    adj = work;
    for (int d = 0; d < DIGITS; d++) begin
      if (work[4*d +: 4] >= 4'd5) adj[4*d +: 4] = work[4*d +: 4] + 4'd3;
    end
  end

`ifdef LEADING_ZERO_BLANK_EN
  logic lead;
`endif

  always_comb begin
    disp = work;
`ifdef LEADING_ZERO_BLANK_EN
    lead = 1'b1;
    for (int d = DIGITS - 1; d >= 1; d--) begin
      if (work[4*d +: 4] != 4'd0) lead = 1'b0;
      if (lead) disp[4*d +: 4] = 4'hF;
    end
`endif
    if (ovf) disp = {DIGITS{4'h9}};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      armed    <= 1'b0;
      shreg    <= '0;
      work     <= '0;
      ovf      <= 1'b0;
      bit_cnt  <= '0;
      hold_cnt <= '0;
      bcd_q    <= {DIGITS{4'hF}};
      ovf_q    <= 1'b0;
    end else begin
      armed <= 1'b1;
      if (hold_cnt != HOLD_MAX) hold_cnt <= hold_cnt + HW'(1);
      case (state)
        S_IDLE: begin
          if (armed && bus.valid) begin
            shreg    <= bus.value;
            work     <= '0;
            ovf      <= 1'b0;
            hold_cnt <= HW'(1);
            bit_cnt  <= CW'(WIDTH);
            state    <= S_CONVERT;
          end
        end
        S_CONVERT: begin
          // A carry out of the top digit means the reading needs more digits.
          work  <= {adj[BW-2:0], shreg[WIDTH-1]};
          ovf   <= ovf | adj[BW-1];
          shreg <= {shreg[WIDTH-2:0], 1'b0};
          if (bit_cnt != '0) bit_cnt <= bit_cnt - CW'(1);
          if (bit_cnt == CW'(1)) state <= S_COMMIT;
        end
        S_COMMIT: begin
          bcd_q <= disp;
          ovf_q <= ovf;
          state <= S_HOLD;
        end
        default: begin
          if (hold_cnt >= HOLD_TC) state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.ready    = (state == S_IDLE) && armed;
  assign bus.busy     = (state == S_CONVERT) || (state == S_COMMIT);
  assign bus.bcd      = bcd_q;
  assign bus.overflow = ovf_q;
endmodule

// File: tb/tb_bcd_display_scheduler.sv
// Bench for bcd_display_scheduler: a 5-digit and a 4-digit instance share stimulus and
// are compared every cycle against a timeline model, plus directed literal expectations.
module tb_bcd_display_scheduler;
  localparam int W    = 16;
  localparam int P    = 32;
  localparam int MAXP = (P > W + 2) ? P : W + 2;

`ifdef LEADING_ZERO_BLANK_EN
  localparam logic [19:0] L1234 = 20'hF1234, L0 = 20'hFFFF0, L42_4 = 20'h0FF42;
  localparam logic [19:0] L7 = 20'hFFFF7, L8 = 20'hFFFF8, L321 = 20'hFF321;
`else
  localparam logic [19:0] L1234 = 20'h01234, L0 = 20'h00000, L42_4 = 20'h00042;
  localparam logic [19:0] L7 = 20'h00007, L8 = 20'h00008, L321 = 20'h00321;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] value = '0;
  logic        valid = 1'b0;
  int          checks = 0;
  int          errors = 0;

  bcd_display_scheduler_if #(.WIDTH(16), .DIGITS(5)) bus5 ();
  bcd_display_scheduler_if #(.WIDTH(16), .DIGITS(4)) bus4 ();

  assign bus5.value = value;
  assign bus5.valid = valid;
  assign bus4.value = value;
  assign bus4.valid = valid;

  bcd_display_scheduler #(.WIDTH(16), .DIGITS(5), .UPDATE_PERIOD(P)) dut5 (
    .clk(clk), .reset(rst), .bus(bus5));
  bcd_display_scheduler #(.WIDTH(16), .DIGITS(4), .UPDATE_PERIOD(P)) dut4 (
    .clk(clk), .reset(rst), .bus(bus4));

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [19:0] act, input logic [19:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int pow10(input int n);
    int r = 1;
    for (int i = 0; i < n; i++) r = r * 10;
    return r;
  endfunction

  // Expected display code for a reading on an nd-digit display.
  function automatic logic [19:0] exp_bcd(input int v, input int nd);
    logic [19:0] r = '0;
    int x = v;
    for (int i = 0; i < nd; i++) begin
      r[4*i +: 4] = (v >= pow10(nd)) ? 4'd9 : 4'(x % 10);
      x = x / 10;
    end
`ifdef LEADING_ZERO_BLANK_EN
    if (v < pow10(nd)) begin
      for (int i = nd - 1; i >= 1; i--) begin
        if (r[4*i +: 4] != 4'd0) break;
        r[4*i +: 4] = 4'hF;
      end
    end
`endif
    return r;
  endfunction

  // Timeline model: outputs as a function of clocks since the last capture.
  int          cyc = 0;
  bit          started = 0;
  bit          m_ready [2];
  bit          m_busy  [2];
  bit          m_ovf   [2];
  logic [19:0] m_bcd   [2];
  bit          inflight[2];
  int          t_cap   [2];
  int          m_val   [2];

  always @(posedge clk) begin
    cyc++;
    started = 1;
    for (int i = 0; i < 2; i++) begin
      int nd;
      int k;
      nd = (i == 0) ? 5 : 4;
      if (rst) begin
        m_ready[i]  = 0;
        m_busy[i]   = 0;
        m_ovf[i]    = 0;
        m_bcd[i]    = (i == 0) ? 20'hFFFFF : 20'h0FFFF;
        inflight[i] = 0;
      end else begin
        if (m_ready[i] && valid) begin
          inflight[i] = 1;
          t_cap[i]    = cyc;
          m_val[i]    = int'(value);
        end
        if (inflight[i]) begin
          k = cyc - t_cap[i];
          m_busy[i] = (k <= W);
          if (k == W + 1) begin
            m_bcd[i] = exp_bcd(m_val[i], nd);
            m_ovf[i] = (m_val[i] >= pow10(nd));
          end
          m_ready[i] = (k >= MAXP);
          if (m_ready[i]) inflight[i] = 0;
        end else begin
          m_ready[i] = 1;
          m_busy[i]  = 0;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (started) begin
      chk("ready5", {19'd0, bus5.ready}, {19'd0, m_ready[0]});
      chk("busy5", {19'd0, bus5.busy}, {19'd0, m_busy[0]});
      chk("ovf5", {19'd0, bus5.overflow}, {19'd0, m_ovf[0]});
      chk("bcd5", bus5.bcd, m_bcd[0]);
      chk("ready4", {19'd0, bus4.ready}, {19'd0, m_ready[1]});
      chk("busy4", {19'd0, bus4.busy}, {19'd0, m_busy[1]});
      chk("ovf4", {19'd0, bus4.overflow}, {19'd0, m_ovf[1]});
      chk("bcd4", {4'h0, bus4.bcd}, m_bcd[1]);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Present v for one edge (display ready), then sit until T+17.
  task automatic send(input logic [15:0] v);
    value = v;
    valid = 1'b1;
    tick(1);
    valid = 1'b0;
    tick(17);
  endtask

  task automatic finish_hold(input string name);
    tick(14);
    chk({name, "_ready_lo"}, {19'd0, bus5.ready}, 20'd0);
    tick(1);
    chk({name, "_ready_hi"}, {19'd0, bus5.ready}, 20'd1);
  endtask

  initial begin
    chk("model_1234", exp_bcd(1234, 5), L1234);
    chk("model_ovf4", exp_bcd(12345, 4), 20'h09999);
    chk("model_42_4", exp_bcd(42, 4), L42_4);

    tick(3);
    chk("rst_bcd", bus5.bcd, 20'hFFFFF);
    chk("rst_ovf", {19'd0, bus5.overflow}, 20'd0);
    chk("rst_busy", {19'd0, bus5.busy}, 20'd0);
    chk("rst_ready", {19'd0, bus5.ready}, 20'd0);
    rst = 1'b0;
    tick(1);
    chk("rel_ready", {19'd0, bus5.ready}, 20'd1);

    value = 16'd1234;
    valid = 1'b1;
    tick(1);
    valid = 1'b0;
    chk("t2_busy_first", {19'd0, bus5.busy}, 20'd1);
    tick(16);
    chk("t2_bcd_before", bus5.bcd, 20'hFFFFF);
    chk("t2_busy_last", {19'd0, bus5.busy}, 20'd1);
    tick(1);
    chk("t2_bcd", bus5.bcd, L1234);
    chk("t2_busy_done", {19'd0, bus5.busy}, 20'd0);
    finish_hold("t2");

    send(16'd0);
    chk("t3_zero", bus5.bcd, L0);
    finish_hold("t3a");
    send(16'd65535);
    chk("t3_max", bus5.bcd, 20'h65535);
    chk("t3_max_ovf", {19'd0, bus5.overflow}, 20'd0);
    chk("t3_max_ovf4", {19'd0, bus4.overflow}, 20'd1);
    finish_hold("t3b");

    send(16'd12345);
    chk("t4_ovf4", {19'd0, bus4.overflow}, 20'd1);
    chk("t4_bcd4", {4'h0, bus4.bcd}, 20'h09999);
    finish_hold("t4a");
    send(16'd42);
    chk("t4_ovf4_clr", {19'd0, bus4.overflow}, 20'd0);
    chk("t4_bcd4_42", {4'h0, bus4.bcd}, L42_4);
    finish_hold("t4b");

    value = 16'd7;
    valid = 1'b1;
    tick(1);
    tick(4);
    value = 16'd8;
    tick(13);
    chk("t5_first", bus5.bcd, L7);
    finish_hold("t5");
    tick(1);
    chk("t5_second_busy", {19'd0, bus5.busy}, 20'd1);
    valid = 1'b0;
    tick(17);
    chk("t5_second", bus5.bcd, L8);
    finish_hold("t5b");

    value = 16'd999;
    valid = 1'b1;
    tick(1);
    valid = 1'b0;
    tick(7);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    chk("t6_bcd", bus5.bcd, 20'hFFFFF);
    chk("t6_busy", {19'd0, bus5.busy}, 20'd0);
    chk("t6_ready_lo", {19'd0, bus5.ready}, 20'd0);
    tick(1);
    chk("t6_ready_hi", {19'd0, bus5.ready}, 20'd1);
    send(16'd321);
    chk("t6_after", bus5.bcd, L321);
    finish_hold("t6");

    for (int n = 0; n < 2500; n++) begin
      if ($urandom_range(0, 3) == 0) begin
        case ($urandom_range(0, 5))
          0:       value = 16'd0;
          1:       value = 16'd65535;
          2:       value = 16'd9999;
          3:       value = 16'd10000;
          4:       value = 16'($urandom_range(0, 99));
          default: value = 16'($urandom_range(0, 65535));
        endcase
      end
      valid = ($urandom_range(0, 3) != 0);
      rst   = ($urandom_range(0, 299) == 0);
      tick(1);
    end
    rst   = 1'b0;
    valid = 1'b0;
    tick(40);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
